// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multi-cycle RISC-V main controller.
// Holds the state encoding, the opcodes the controller understands, the
// datapath select/ALU-class encodings and the control-vector struct that the
// output decoder hands back to the FSM.
package multicycle_ctrl_pkg;

    // State codes are visible on state_dbg, so the values are fixed.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMREAD = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALUWB   = 4'd7,
        S_EXEC_I  = 4'd8,
        S_JAL     = 4'd9,
        S_BEQ     = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_MEMDATA   = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } src_b_t;

    // Per-state control vector. needs_ready marks strobes (ir_write,
    // pc_update) that only fire once memory completes the access.
    typedef struct packed {
        logic        pc_update;
        logic        needs_ready;
        logic        branch;
        logic        adr_src;
        logic        mem_write;
        logic        ir_write;
        logic        reg_write;
        logic        illegal;
        result_src_t result_src;
        src_a_t      alu_src_a;
        src_b_t      alu_src_b;
        alu_op_t     alu_op;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{
        pc_update:   1'b0,
        needs_ready: 1'b0,
        branch:      1'b0,
        adr_src:     1'b0,
        mem_write:   1'b0,
        ir_write:    1'b0,
        reg_write:   1'b0,
        illegal:     1'b0,
        result_src:  RES_ALUOUT,
        alu_src_a:   SRCA_PC,
        alu_src_b:   SRCB_RS2,
        alu_op:      ALU_ADD
    };

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Controller <-> datapath bundle.
//   master (controller): reads opcode, zero, mem_ready; drives the write
//                        enables, mux selects and the ALU op class.
//   slave  (datapath)  : the mirror image.
interface multicycle_ctrl_fsm_if;

    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, reg_write,
               result_src, alu_src_a, alu_src_b, alu_op
    );

endinterface

// File: rtl/mc_ctrl_out_decode.sv
// Moore output table: current state -> control vector. Purely combinational.
//   state : current controller state
//   ctrl  : control vector for that state (unused codes give all-idle)
module mc_ctrl_out_decode
    import multicycle_ctrl_pkg::*;
(
    input  state_t state,
    output ctrl_t  ctrl
);

    always_comb begin
        // NOTE: every field gets a default before the case, so no path
        // leaves a field unassigned and no latch is inferred.
        ctrl = CTRL_IDLE;
        case (state)
            S_FETCH: begin
                ctrl.alu_src_b   = SRCB_FOUR;
                ctrl.result_src  = RES_ALURESULT;
                ctrl.ir_write    = 1'b1;
                ctrl.pc_update   = 1'b1;
                ctrl.needs_ready = 1'b1;
            end
            S_DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMREAD: ctrl.adr_src = 1'b1;
            S_MEMWB: begin
                ctrl.result_src = RES_MEMDATA;
                ctrl.reg_write  = 1'b1;
            end
            S_MEMWR: begin
                ctrl.adr_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: ctrl.reg_write = 1'b1;
            S_EXEC_I: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_JAL: begin
                // Computes the link value OldPC+4; the target came from DECODE.
                ctrl.alu_src_a = SRCA_OLDPC;
                ctrl.alu_src_b = SRCB_FOUR;
                ctrl.pc_update = 1'b1;
            end
            S_BEQ: begin
                ctrl.alu_src_a = SRCA_RS1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.branch    = 1'b1;
            end
            S_TRAP:  ctrl.illegal = 1'b1;
            default: ctrl = CTRL_IDLE;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM of the multi-cycle RISC-V core.
//   clk       : system clock, rising edge
//   rst       : asynchronous active-low reset
//   bus       : controller side of the datapath bundle (master modport)
//   state_dbg : current state code
//   illegal   : high while trapped on an unsupported opcode
//   instret   : retired-instruction count, wraps modulo 2^CNT_W
module multicycle_ctrl_fsm
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_ctrl_fsm_if.master   bus,
    output logic [3:0]              state_dbg,
    output logic                    illegal,
    output logic [CNT_W-1:0]        instret
);

    state_t           state_q;
    state_t           state_d;
    ctrl_t            ctrl;
    logic             retire;
    logic [CNT_W-1:0] instret_q;

    always_ff @(posedge clk or negedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q <= state_d;
            if (retire) begin
                instret_q <= instret_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                // Only LW/SW reach here; anything else means a corrupted IR.
                if (bus.opcode == OP_LW) begin
                    state_d = S_MEMREAD;
                end else if (bus.opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEMREAD: state_d = bus.mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:   state_d = S_FETCH;
            S_MEMWR:   state_d = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC_R:  state_d = S_ALUWB;
            S_EXEC_I:  state_d = S_ALUWB;
            S_JAL:     state_d = S_ALUWB;
            S_ALUWB:   state_d = S_FETCH;
            S_BEQ:     state_d = S_FETCH;
            S_TRAP:    state_d = S_TRAP;
            default:   state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that returns to FETCH from a
    // completing state; a stalled store retires only when memory accepts it.
    assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) ||
                    (state_q == S_BEQ)   ||
                    ((state_q == S_MEMWR) && bus.mem_ready);

    mc_ctrl_out_decode u_out_decode (
        .state (state_q),
        .ctrl  (ctrl)
    );

    // Write enables are gated by rst directly so they drop the instant reset
    // asserts, even though FETCH would otherwise raise ir_write/pc_write.
    assign bus.pc_write  = rst & ((ctrl.pc_update & (bus.mem_ready | ~ctrl.needs_ready)) |
                                  (ctrl.branch & bus.zero));
    assign bus.ir_write  = rst & ctrl.ir_write & (bus.mem_ready | ~ctrl.needs_ready);
    assign bus.mem_write = rst & ctrl.mem_write;
    assign bus.reg_write = rst & ctrl.reg_write;

    assign bus.adr_src    = ctrl.adr_src;
    assign bus.result_src = ctrl.result_src;
    assign bus.alu_src_a  = ctrl.alu_src_a;
    assign bus.alu_src_b  = ctrl.alu_src_b;
    assign bus.alu_op     = ctrl.alu_op;

    assign state_dbg = state_q;
    assign illegal   = ctrl.illegal;
    assign instret   = instret_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomised self-checking bench for multicycle_ctrl_fsm. Two instances share
// the same stimulus: one with a 32-bit retire counter, one with a 4-bit one.
module tb_multicycle_ctrl_fsm;
    import multicycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  state_dbg, state_dbg4;
    logic        illegal, illegal4;
    logic [31:0] instret;
    logic [3:0]  instret4;

    int n_checks = 0;
    int n_fail   = 0;
    int retired  = 0;

    multicycle_ctrl_fsm_if bus();
    multicycle_ctrl_fsm_if bus4();

    assign bus4.opcode    = bus.opcode;
    assign bus4.zero      = bus.zero;
    assign bus4.mem_ready = bus.mem_ready;

    multicycle_ctrl_fsm #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst), .bus(bus.master),
        .state_dbg(state_dbg), .illegal(illegal), .instret(instret)
    );

    multicycle_ctrl_fsm #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4.master),
        .state_dbg(state_dbg4), .illegal(illegal4), .instret(instret4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic any_we();
        return bus.pc_write | bus.ir_write | bus.mem_write | bus.reg_write;
    endfunction

    // Called at a negedge: assert reset, verify reset state, release.
    task automatic do_reset();
        rst = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        check("rst_state", state_dbg, 0);
        check("rst_we", any_we(), 0);
        check("rst_illegal", illegal, 0);
        check("rst_instret", instret, 0);
        check("rst_instret4", instret4, 0);
        @(negedge clk);
        rst = 1'b1;
        retired = 0;
    endtask

    // Runs one instruction from FETCH. The expected state path comes straight
    // from the instruction class and the chosen stall counts; wf = stall
    // cycles in FETCH, wm = stall cycles in MEMREAD/MEMWR.
    task automatic run_instr(input logic [6:0] op, input logic z, input int wf, input int wm);
        int  path[$];
        bit  rdy[$];
        int  n_rw = 0, n_mw = 0, n_iw = 0, n_pw = 0, n_adr = 0;
        logic [1:0] wb_src = 2'b11;
        bit  writes, legal;
        int  exp_pw, exp_mw, exp_adr;

        for (int i = 0; i < wf; i++) begin path.push_back(0); rdy.push_back(1'b0); end
        path.push_back(0); rdy.push_back(1'b1);
        path.push_back(1); rdy.push_back(1'($urandom_range(0, 1)));
        legal = 1'b1;
        case (op)
            OP_LW: begin
                path.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < wm; i++) begin path.push_back(3); rdy.push_back(1'b0); end
                path.push_back(3); rdy.push_back(1'b1);
                path.push_back(4); rdy.push_back(1'($urandom_range(0, 1)));
            end
            OP_SW: begin
                path.push_back(2); rdy.push_back(1'($urandom_range(0, 1)));
                for (int i = 0; i < wm; i++) begin path.push_back(5); rdy.push_back(1'b0); end
                path.push_back(5); rdy.push_back(1'b1);
            end
            OP_R:   begin path.push_back(6); path.push_back(7); rdy.push_back(1'b0); rdy.push_back(1'b1); end
            OP_I:   begin path.push_back(8); path.push_back(7); rdy.push_back(1'b1); rdy.push_back(1'b0); end
            OP_JAL: begin path.push_back(9); path.push_back(7); rdy.push_back(1'b0); rdy.push_back(1'b0); end
            OP_BEQ: begin path.push_back(10); rdy.push_back(1'($urandom_range(0, 1))); end
            default: begin path.push_back(11); rdy.push_back(1'b1); legal = 1'b0; end
        endcase
        writes = (op == OP_LW) || (op == OP_R) || (op == OP_I) || (op == OP_JAL);

        for (int c = 0; c < path.size(); c++) begin
            bus.opcode    = op;
            bus.mem_ready = rdy[c];
            bus.zero      = (path[c] == 10) ? z : 1'($urandom_range(0, 1));
            #1;
            check("state", state_dbg, path[c]);
            check("state4", state_dbg4, path[c]);
            check("illegal", illegal, path[c] == 11);
            check("reg_write_slot", bus.reg_write, writes && (c == path.size() - 1));
            n_rw  += bus.reg_write;
            n_mw  += bus.mem_write;
            n_iw  += bus.ir_write;
            n_pw  += bus.pc_write;
            n_adr += bus.adr_src;
            if (bus.reg_write) wb_src = bus.result_src;
            @(posedge clk);
            @(negedge clk);
        end

        exp_pw  = 1 + ((op == OP_JAL) ? 1 : 0) + ((op == OP_BEQ && z) ? 1 : 0);
        exp_mw  = (op == OP_SW) ? wm + 1 : 0;
        exp_adr = (op == OP_SW || op == OP_LW) ? wm + 1 : 0;
        if (legal) retired++;
        check("n_reg_write", n_rw, writes ? 1 : 0);
        check("n_mem_write", n_mw, exp_mw);
        check("n_ir_write", n_iw, 1);
        check("n_pc_write", n_pw, exp_pw);
        check("n_adr_src", n_adr, exp_adr);
        if (writes) check("wb_result_src", wb_src, (op == OP_LW) ? 2'b01 : 2'b00);
        check("instret", instret, retired);
        check("instret4", instret4, retired % 16);
    endtask

    logic [6:0] legal_ops [6];

    initial begin
        legal_ops[0] = OP_LW; legal_ops[1] = OP_SW;  legal_ops[2] = OP_R;
        legal_ops[3] = OP_I;  legal_ops[4] = OP_JAL; legal_ops[5] = OP_BEQ;

        // Reset held low with an R-type opcode on the bus.
        rst = 1'b0;
        bus.opcode = OP_R;
        bus.mem_ready = 1'b1;
        bus.zero = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("hold_state", state_dbg, 0);
        check("hold_we", any_we(), 0);
        check("hold_instret", instret, 0);
        check("hold_adr_src", bus.adr_src, 0);
        check("hold_alu_src_b", bus.alu_src_b, 2'b10);
        check("hold_result_src", bus.result_src, 2'b10);
        @(negedge clk);
        rst = 1'b1;

        // Directed instructions from FETCH.
        run_instr(OP_R,   1'b0, 0, 0);
        run_instr(OP_LW,  1'b0, 0, 0);
        run_instr(OP_SW,  1'b0, 0, 3);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 0, 0);
        run_instr(OP_JAL, 1'b0, 0, 0);
        run_instr(OP_I,   1'b0, 2, 0);
        run_instr(OP_LW,  1'b1, 1, 2);

        // Random legal instruction stream with random memory stalls.
        for (int k = 0; k < 150; k++) begin
            run_instr(legal_ops[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // 16 I-types: 4-bit counter must wrap back to 0.
        do_reset();
        for (int k = 0; k < 16; k++) run_instr(OP_I, 1'b0, 0, 0);
        check("wrap_instret4", instret4, 0);
        check("wrap_instret", instret, 16);

        // Reset asserted while in EXEC_I: no writeback, counter clears.
        run_instr(OP_R, 1'b0, 0, 0);
        bus.opcode = OP_I;
        bus.mem_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        #1;
        check("mid_exec_i", state_dbg, 8);
        rst = 1'b0;
        #1;
        check("mid_rst_state", state_dbg, 0);
        check("mid_rst_reg_write", bus.reg_write, 0);
        check("mid_rst_instret", instret, 0);
        check("mid_rst_instret4", instret4, 0);
        @(negedge clk);
        #1;
        check("mid_rst_hold_rw", bus.reg_write, 0);
        @(negedge clk);
        rst = 1'b1;
        retired = 0;
        run_instr(OP_I, 1'b0, 0, 0);

        // Unsupported opcode traps and stays trapped until reset.
        run_instr(7'b0000000, 1'b0, 0, 0);
        for (int k = 0; k < 20; k++) begin
            bus.opcode    = legal_ops[$urandom_range(0, 5)];
            bus.mem_ready = 1'($urandom_range(0, 1));
            bus.zero      = 1'($urandom_range(0, 1));
            #1;
            check("trap_state", state_dbg, 11);
            check("trap_illegal", illegal, 1);
            check("trap_we", any_we(), 0);
            @(negedge clk);
        end
        check("trap_instret", instret, retired);
        do_reset();
        run_instr(OP_BEQ, 1'b1, 1, 0);
        run_instr(OP_SW,  1'b0, 2, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
